// File: rtl/multicycle_maindec.sv
// Main-decoder FSM for the multicycle RISC-V core: sequences Fetch/Decode/Execute/Memory/Writeback and drives datapath strobes.
// Latency: lw 5, sw/R/I/jal 4, beq 3, illegal 3 (2 without trap) cycles, plus one cycle per memory wait.
// Backpressure: with MEM_HANDSHAKE=1, Fetch/MemRead/MemWr hold until MemReady; otherwise MemReady is ignored.
module multicycle_maindec #(
    parameter bit MEM_HANDSHAKE = 1'b0,
    parameter bit ILLEGAL_TRAP  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       MemReady,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       Illegal,
    output logic       Retire,
    output logic [3:0] State
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMREAD = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECR   = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_EXECI   = 4'd8;
    localparam logic [3:0] S_JAL     = 4'd9;
    localparam logic [3:0] S_BEQ     = 4'd10;
    localparam logic [3:0] S_TRAP    = 4'd11;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    logic [3:0] state;
    logic [3:0] next_state;
    logic       rdy;

    assign rdy   = MEM_HANDSHAKE ? MemReady : 1'b1;
    assign State = state;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:   next_state = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = S_EXECI;
                    OP_JAL:       next_state = S_JAL;
                    OP_BEQ:       next_state = S_BEQ;
                    default:      next_state = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR:  next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWR;
            S_MEMREAD: next_state = rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:   next_state = S_FETCH;
            S_MEMWR:   next_state = rdy ? S_FETCH : S_MEMWR;
            S_EXECR:   next_state = S_ALUWB;
            S_EXECI:   next_state = S_ALUWB;
            S_ALUWB:   next_state = S_FETCH;
            S_JAL:     next_state = S_ALUWB;
            S_BEQ:     next_state = S_FETCH;
            S_TRAP:    next_state = S_FETCH;
            default:   next_state = S_FETCH;
        endcase
    end

    always_comb begin
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        Illegal   = 1'b0;
        Retire    = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = rdy;
                PCUpdate  = rdy;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                Retire    = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                Retire   = rdy;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                Retire   = 1'b1;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
                Retire  = 1'b1;
            end
            S_TRAP:  Illegal = 1'b1;
            default: ;
        endcase
        // Reset abandons the current instruction, so no strobe may escape this cycle.
        if (reset) begin
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCUpdate = 1'b0;
            Branch   = 1'b0;
            Illegal  = 1'b0;
            Retire   = 1'b0;
        end
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_maindec.sv
// Scoreboarded directed test of multicycle_maindec: one instance without handshake (trap on),
// one with handshake (trap off); expected per-cycle outputs are queued by stimulus, checked by a monitor.
module tb_multicycle_maindec;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, rst1 = 1'b1;
    logic [6:0] op0 = 7'd0, op1 = 7'd0;
    logic       mr0 = 1'b0, mr1 = 1'b0;

    logic       rw0, mw0, irw0, pcu0, br0, as0, ill0, ret0;
    logic [1:0] rs0, sa0, sb0, ao0, im0;
    logic [3:0] st0;
    logic       rw1, mw1, irw1, pcu1, br1, as1, ill1, ret1;
    logic [1:0] rs1, sa1, sb1, ao1, im1;
    logic [3:0] st1;

    multicycle_maindec #(.MEM_HANDSHAKE(1'b0), .ILLEGAL_TRAP(1'b1)) dut0 (
        .clk(clk), .reset(rst0), .op(op0), .MemReady(mr0),
        .RegWrite(rw0), .MemWrite(mw0), .IRWrite(irw0), .PCUpdate(pcu0), .Branch(br0),
        .AdrSrc(as0), .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUOp(ao0),
        .ImmSrc(im0), .Illegal(ill0), .Retire(ret0), .State(st0)
    );

    multicycle_maindec #(.MEM_HANDSHAKE(1'b1), .ILLEGAL_TRAP(1'b0)) dut1 (
        .clk(clk), .reset(rst1), .op(op1), .MemReady(mr1),
        .RegWrite(rw1), .MemWrite(mw1), .IRWrite(irw1), .PCUpdate(pcu1), .Branch(br1),
        .AdrSrc(as1), .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUOp(ao1),
        .ImmSrc(im1), .Illegal(ill1), .Retire(ret1), .State(st1)
    );

    // Vector layout: state, RegWrite, MemWrite, IRWrite, PCUpdate, Branch, AdrSrc,
    // ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, Retire.
    logic [21:0] obs0, obs1;
    assign obs0 = {st0, rw0, mw0, irw0, pcu0, br0, as0, rs0, sa0, sb0, ao0, im0, ill0, ret0};
    assign obs1 = {st1, rw1, mw1, irw1, pcu1, br1, as1, rs1, sa1, sb1, ao1, im1, ill1, ret1};

    logic [21:0] q_exp[$];
    int          q_inst[$];
    int          q_id[$];
    int          checks = 0;
    int          errors = 0;
    int          step_no = 0;

    // Expected outputs for a given state, written out from the state table.
    function automatic logic [21:0] expv(input logic [3:0] st, input logic [6:0] o,
                                         input logic rdy, input logic rs);
        logic rw, mw, irw, pcu, br, as, ill, ret;
        logic [1:0] rsrc, sa, sb, ao, im;
        {rw, mw, irw, pcu, br, as, ill, ret} = 8'd0;
        {rsrc, sa, sb, ao} = 8'd0;
        case (st)
            4'd0:  begin sb = 2'b10; rsrc = 2'b10; irw = rdy; pcu = rdy; end
            4'd1:  begin sa = 2'b01; sb = 2'b01; end
            4'd2:  begin sa = 2'b10; sb = 2'b01; end
            4'd3:  as = 1'b1;
            4'd4:  begin rsrc = 2'b01; rw = 1'b1; ret = 1'b1; end
            4'd5:  begin as = 1'b1; mw = 1'b1; ret = rdy; end
            4'd6:  begin sa = 2'b10; ao = 2'b10; end
            4'd7:  begin rw = 1'b1; ret = 1'b1; end
            4'd8:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            4'd9:  begin sa = 2'b01; sb = 2'b10; pcu = 1'b1; end
            4'd10: begin sa = 2'b10; ao = 2'b01; br = 1'b1; ret = 1'b1; end
            4'd11: ill = 1'b1;
            default: ;
        endcase
        im = (o == SW) ? 2'b01 : (o == BEQ) ? 2'b10 : (o == JAL) ? 2'b11 : 2'b00;
        if (rs) {rw, mw, irw, pcu, br, ill, ret} = 7'd0;
        return {st, rw, mw, irw, pcu, br, as, rsrc, sa, sb, ao, im, ill, ret};
    endfunction

    // One cycle of stimulus on instance inst; st is the hand-derived state expected this cycle.
    task automatic cyc(input int inst, input logic [6:0] o, input logic rdy,
                       input logic rs, input logic [3:0] st);
        @(posedge clk);
        #1;
        if (inst == 0) begin op0 = o; mr0 = rdy; rst0 = rs; end
        else           begin op1 = o; mr1 = rdy; rst1 = rs; end
        step_no++;
        q_exp.push_back(expv(st, o, (inst == 0) ? 1'b1 : rdy, rs));
        q_inst.push_back(inst);
        q_id.push_back(step_no);
    endtask

    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            logic [21:0] e, a;
            int inst, id;
            e = q_exp.pop_front();
            inst = q_inst.pop_front();
            id = q_id.pop_front();
            a = (inst == 0) ? obs0 : obs1;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL step%0d dut%0d: got state=%0d bits=%b, expected state=%0d bits=%b",
                         id, inst, a[21:18], a[17:0], e[21:18], e[17:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        // dut0: no handshake, trap enabled. First cycle checks the reset state.
        cyc(0, LW, 1, 1, 0);
        cyc(0, LW, 0, 0, 0); cyc(0, LW, 0, 0, 1); cyc(0, LW, 0, 0, 2);
        cyc(0, LW, 0, 0, 3); cyc(0, LW, 0, 0, 4);
        cyc(0, SW, 0, 0, 0); cyc(0, SW, 0, 0, 1); cyc(0, SW, 0, 0, 2); cyc(0, SW, 0, 0, 5);
        cyc(0, RT, 0, 0, 0); cyc(0, RT, 0, 0, 1); cyc(0, RT, 0, 0, 6); cyc(0, RT, 0, 0, 7);
        cyc(0, IT, 0, 0, 0); cyc(0, IT, 0, 0, 1); cyc(0, IT, 0, 0, 8); cyc(0, IT, 0, 0, 7);
        cyc(0, JAL, 0, 0, 0); cyc(0, JAL, 0, 0, 1); cyc(0, JAL, 0, 0, 9); cyc(0, JAL, 0, 0, 7);
        cyc(0, BEQ, 0, 0, 0); cyc(0, BEQ, 0, 0, 1); cyc(0, BEQ, 0, 0, 10);
        cyc(0, BAD, 0, 0, 0); cyc(0, BAD, 0, 0, 1); cyc(0, BAD, 0, 0, 11);
        // Reset in MemRead abandons the lw.
        cyc(0, LW, 0, 0, 0); cyc(0, LW, 0, 0, 1); cyc(0, LW, 0, 0, 2);
        cyc(0, LW, 0, 1, 3); cyc(0, RT, 0, 0, 0); cyc(0, RT, 0, 0, 1);
        cyc(0, RT, 0, 1, 6);

        // dut1: handshake on, trap disabled.
        cyc(1, SW, 0, 1, 0);
        cyc(1, SW, 0, 0, 0); cyc(1, SW, 1, 0, 0); cyc(1, SW, 0, 0, 1); cyc(1, SW, 0, 0, 2);
        cyc(1, SW, 0, 0, 5); cyc(1, SW, 0, 0, 5); cyc(1, SW, 0, 0, 5); cyc(1, SW, 1, 0, 5);
        cyc(1, LW, 1, 0, 0); cyc(1, LW, 0, 0, 1); cyc(1, LW, 0, 0, 2);
        cyc(1, LW, 0, 0, 3); cyc(1, LW, 1, 0, 3); cyc(1, LW, 0, 0, 4);
        cyc(1, BAD, 1, 0, 0); cyc(1, BAD, 0, 0, 1); cyc(1, BAD, 0, 0, 0);
        // Reset in MemRead, then Fetch stalled by MemReady=0.
        cyc(1, LW, 1, 0, 0); cyc(1, LW, 0, 0, 1); cyc(1, LW, 0, 0, 2);
        cyc(1, LW, 1, 1, 3); cyc(1, LW, 0, 0, 0); cyc(1, LW, 0, 0, 0);
        cyc(1, LW, 1, 0, 0); cyc(1, LW, 0, 0, 1);
        // Reset during a MemWr stall: no Retire, back to Fetch.
        cyc(1, SW, 0, 0, 2); cyc(1, SW, 0, 0, 5); cyc(1, SW, 1, 1, 5); cyc(1, SW, 0, 0, 0);

        for (int i = 0; i < 10 && q_exp.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
